// File: rtl/ltl_monitor_pkg.sv
// Shared types and constants for the LTL monitor sequencer slice.
package ltl_monitor_pkg;

   localparam int SYMBOL_W        = 8;
   localparam int DEF_IDX_W       = 16;
   localparam int DEF_NUM_REPORTS = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RST   = 3'd1,
      PRIME = 3'd2,
      RUN   = 3'd3,
      FLUSH = 3'd4
   } seq_state_e;

   // Layout of one report entry for the default configuration.
   typedef struct packed {
      logic                       last;
      logic [DEF_IDX_W-1:0]       idx;
      logic [DEF_NUM_REPORTS-1:0] rpt;
   } report_entry_t;

endpackage

// File: rtl/ltl_monitor_sequencer_if.sv
// Trace stream (s_*) and report stream (r_*) of the monitor sequencer.
interface ltl_monitor_sequencer_if
   import ltl_monitor_pkg::*;
#(
   parameter int IDX_W       = DEF_IDX_W,
   parameter int NUM_REPORTS = DEF_NUM_REPORTS
) ();

   logic                         s_valid;
   logic                         s_ready;
   logic [SYMBOL_W-1:0]          s_symbol;
   logic                         s_last;
   logic                         r_valid;
   logic                         r_ready;
   logic [IDX_W+NUM_REPORTS:0]   r_data;

   modport master (
      output s_valid, s_symbol, s_last, r_ready,
      input  s_ready, r_valid, r_data
   );

   modport slave (
      input  s_valid, s_symbol, s_last, r_ready,
      output s_ready, r_valid, r_data
   );

endinterface

// File: rtl/ltl_report_fifo.sv
// First-word-fall-through report FIFO with registered storage and free count.
module ltl_report_fifo #(
   parameter int  DEPTH   = 8,
   parameter type entry_t = logic
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  entry_t                   push_data,
   input  logic                     pop,
   output logic                     valid,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   free
);

   localparam int              PTR_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]  ONE_C   = (PTR_W+1)'(1);

   entry_t           mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic             full_s;
   logic             do_push_s;
   logic             do_pop_s;

   assign full_s    = (count_r == DEPTH_C);
   assign do_pop_s  = pop && (count_r != '0);
   assign do_push_s = push && (!full_s || do_pop_s);

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + ONE_C;
            2'b01:   count_r <= count_r - ONE_C;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage; contents need no reset since occupancy gates visibility.
   always_ff @(posedge clk) begin
      if (do_push_s) mem_r[wr_ptr_r] <= push_data;
   end

   assign valid = (count_r != '0);
   assign head  = mem_r[rd_ptr_r];
   assign free  = DEPTH_C - count_r;

endmodule

// File: rtl/ltl_monitor_sequencer.sv
// Sequences one LTL automaton cluster over a symbol trace and queues its reports,
// tagged with the symbol index, for the host.
module ltl_monitor_sequencer
   import ltl_monitor_pkg::*;
#(
   parameter int NUM_REPORTS = DEF_NUM_REPORTS,
   parameter int IDX_W       = DEF_IDX_W,
   parameter int FIFO_DEPTH  = 8,
   parameter int RST_CYCLES  = 2,
   parameter bit REPORT_ALL  = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cfg_start,
   input  logic                    cfg_abort,
   ltl_monitor_sequencer_if.slave  bus,
   output logic                    am_reset,
   output logic                    am_run,
   output logic [SYMBOL_W-1:0]     am_symbols,
   input  logic [NUM_REPORTS-1:0]  am_report,
   output logic                    busy,
   output logic [7:0]              drop_cnt
);

   localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CNT_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef struct packed {
      logic                   last;
      logic [IDX_W-1:0]       idx;
      logic [NUM_REPORTS-1:0] rpt;
   } cap_entry_t;

   seq_state_e        state_r;
   logic [CNT_W-1:0]  rst_cnt_r;
   logic [IDX_W-1:0]  idx_r;
   logic [IDX_W-1:0]  cap_idx_r;
   logic              cap_pend_r;
   logic              cap_last_r;
   logic [7:0]        drop_cnt_r;
   logic [FREE_W-1:0] fifo_free_s;
   logic              fifo_valid_s;
   logic              s_ready_s;
   logic              accept_s;
   logic              start_s;
   logic              push_s;
   logic              pop_s;
   cap_entry_t        push_entry_s;
   cap_entry_t        head_entry_s;

   // Symbol acceptance keeps one FIFO slot in reserve for an in-flight capture.
   always_comb begin
      s_ready_s = 1'b0;
      case (state_r)
         PRIME:   s_ready_s = (fifo_free_s >= FREE_W'(2));
         RUN:     s_ready_s = (fifo_free_s >= FREE_W'(2)) ||
                              ((fifo_free_s == FREE_W'(1)) && !cap_pend_r);
         default: s_ready_s = 1'b0;
      endcase
   end

   // Reset is released in the very cycle the first symbol is accepted.
   always_comb begin
      am_reset = 1'b1;
      case (state_r)
         RUN, FLUSH: am_reset = 1'b0;
         PRIME:      am_reset = !accept_s;
         default:    am_reset = 1'b1;
      endcase
   end

   assign accept_s     = bus.s_valid && s_ready_s;
   assign start_s      = cfg_start && !cfg_abort && (state_r == IDLE);
   assign push_s       = cap_pend_r && !cfg_abort &&
                         (REPORT_ALL || (am_report != '0) || cap_last_r);
   assign pop_s        = fifo_valid_s && bus.r_ready;
   assign push_entry_s = '{last: cap_last_r, idx: cap_idx_r, rpt: am_report};

   // Sequencer FSM, symbol index and capture register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         rst_cnt_r  <= '0;
         idx_r      <= '0;
         cap_idx_r  <= '0;
         cap_pend_r <= 1'b0;
         cap_last_r <= 1'b0;
      end else if (cfg_abort) begin
         state_r    <= IDLE;
         cap_pend_r <= 1'b0;
      end else begin
         cap_pend_r <= accept_s;
         if (accept_s) begin
            cap_last_r <= bus.s_last;
            cap_idx_r  <= (state_r == PRIME) ? '0 : idx_r;
            idx_r      <= (state_r == PRIME) ? IDX_W'(1) : idx_r + IDX_W'(1);
         end
         case (state_r)
            IDLE: begin
               if (cfg_start) begin
                  state_r   <= RST;
                  rst_cnt_r <= CNT_W'(RST_CYCLES - 1);
               end
            end
            RST: begin
               if (rst_cnt_r == '0) state_r <= PRIME;
               else                 rst_cnt_r <= rst_cnt_r - CNT_W'(1);
            end
            PRIME:   if (accept_s) state_r <= bus.s_last ? FLUSH : RUN;
            RUN:     if (accept_s && bus.s_last) state_r <= FLUSH;
            FLUSH:   state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   // Saturating count of captures lost to a full FIFO.
   always_ff @(posedge clk) begin
      if (reset || start_s) begin
         drop_cnt_r <= 8'd0;
      end else if (push_s && (fifo_free_s == '0) && !pop_s && (drop_cnt_r != 8'hFF)) begin
         drop_cnt_r <= drop_cnt_r + 8'd1;
      end
   end

   ltl_report_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (cap_entry_t)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data (push_entry_s),
      .pop       (pop_s),
      .valid     (fifo_valid_s),
      .head      (head_entry_s),
      .free      (fifo_free_s)
   );

   assign bus.s_ready = s_ready_s;
   assign bus.r_valid = fifo_valid_s;
   assign bus.r_data  = head_entry_s;
   assign am_run      = accept_s;
   assign am_symbols  = bus.s_symbol;
   assign busy        = (state_r != IDLE);
   assign drop_cnt    = drop_cnt_r;

endmodule
